// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the reset PC, the fault-entry NOP word and the buffer entry layout.
package inst_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;  // reset value lives in the pc register
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam int PC_W   = 32;
  localparam int INST_W = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              fault;
  } fetch_ent_t;

  localparam int ENT_W = $bits(fetch_ent_t);

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/grant/response bus plus the decode valid/ready port.
// master is the fetch-stage view; slave is the memory/decode environment view.
interface inst_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_err;

  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata, imem_err,
    output id_valid, id_pc, id_inst, id_fault,
    input  id_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata, imem_err,
    input  id_valid, id_pc, id_inst, id_fault,
    output id_ready
  );

endinterface

// File: rtl/inst_fetch_if_buf.sv
// Two-entry synchronous FIFO with a flush that empties it in one cycle.
// The head word comes straight from the storage registers.
module if_buf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: issues pc to instruction memory, tracks outstanding
// grants, buffers returned words for decode and discards stale responses on redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  pc,
  output logic         pc_en,
  input  logic         flush,
  inst_fetch_if.master bus
);

  logic [1:0]  outst;
  logic [2:0]  drop;
  logic        fault_pending;

  logic [1:0]  buf_count;
  logic [1:0]  pcq_count;
  logic [31:0] pcq_head;
  fetch_ent_t  ent_in;
  fetch_ent_t  ent_out;

  logic        deq;
  logic        gnt_acc;
  logic        live_resp;
  logic        mis_enq;
  logic        buf_push;
  logic [2:0]  used;

  assign bus.id_valid = (buf_count != 2'd0);
  assign deq          = bus.id_valid && bus.id_ready && !flush;

  // A same-cycle dequeue frees its slot for the request issued now; this keeps
  // one fetch per cycle in steady state while still holding outst + count <= 2.
  assign used = {1'b0, outst} + {1'b0, buf_count} - {2'b00, deq};

  assign bus.imem_req  = !rst && !flush && !fault_pending &&
                         (pc[1:0] == 2'b00) && (used < 3'd2);
  assign bus.imem_addr = pc;
  assign gnt_acc       = bus.imem_req && bus.imem_gnt;
  assign pc_en         = gnt_acc;

  assign live_resp = bus.imem_rvalid && !flush && (drop == 3'd0) && (pcq_count != 2'd0);

  assign mis_enq = !flush && !fault_pending && (pc[1:0] != 2'b00) &&
                   (outst == 2'd0) && (drop == 3'd0) &&
                   ((buf_count != 2'd2) || deq);

  assign buf_push = live_resp || mis_enq;

  always_comb begin
    ent_in = '0;
    if (live_resp) begin
      ent_in.pc    = pcq_head;
      ent_in.inst  = bus.imem_rdata;
      ent_in.fault = bus.imem_err;
    end else begin
      ent_in.pc    = pc;
      ent_in.inst  = NOP_INST;
      ent_in.fault = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst         <= 2'd0;
      drop          <= 3'd0;
      fault_pending <= 1'b0;
    end else if (flush) begin
      // Everything still in flight becomes stale; a response landing now is one of them.
      outst         <= 2'd0;
      drop          <= drop + {1'b0, outst} -
                       {2'b00, bus.imem_rvalid && ((drop != 3'd0) || (outst != 2'd0))};
      fault_pending <= 1'b0;
    end else begin
      outst <= outst + {1'b0, gnt_acc} - {1'b0, live_resp};
      if (bus.imem_rvalid && (drop != 3'd0)) drop <= drop - 3'd1;
      if (mis_enq || (live_resp && bus.imem_err)) fault_pending <= 1'b1;
    end
  end

  if_buf #(.W(PC_W)) u_pcq (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (gnt_acc),
    .wdata (pc),
    .pop   (live_resp),
    .head  (pcq_head),
    .count (pcq_count)
  );

  if_buf #(.W(ENT_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (buf_push),
    .wdata (ent_in),
    .pop   (deq),
    .head  (ent_out),
    .count (buf_count)
  );

  assign bus.id_pc    = ent_out.pc;
  assign bus.id_inst  = ent_out.inst;
  assign bus.id_fault = ent_out.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: the stimulus queues expected decode entries,
// a negedge monitor pops and compares every accepted entry.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] pc;
  logic [31:0] tgt = 32'h0;
  logic        pc_en;
  logic        resp_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  int          n_total = 0;
  int          n_pass = 0;
  int          n_en;
  fetch_ent_t  exp_q[$];
  logic [31:0] pend[$];

  inst_fetch_if bus();

  inst_fetch #(.NOP_INST(32'h0000_0013)) dut (
    .clk   (clk),
    .rst   (rst),
    .pc    (pc),
    .pc_en (pc_en),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // pc register model: redirect target wins, otherwise advance on pc_en
  always @(posedge clk or posedge rst) begin
    if (rst)        pc <= 32'h0;
    else if (flush) pc <= tgt;
    else if (pc_en) pc <= pc + 32'd4;
  end

  // in-order memory; a grant can be answered on the very next cycle
  always @(posedge clk) begin
    logic [31:0] a;
    if (bus.imem_req && bus.imem_gnt) pend.push_back(bus.imem_addr);
    if (resp_en && pend.size() > 0) begin
      a = pend.pop_front();
      bus.imem_rvalid <= 1'b1;
      bus.imem_rdata  <= a + 32'h1000_0000;
      bus.imem_err    <= (a == err_addr);
    end else begin
      bus.imem_rvalid <= 1'b0;
      bus.imem_err    <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.id_valid && bus.id_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got pc %h inst %h fault %b, required no entry",
                 bus.id_pc, bus.id_inst, bus.id_fault);
      end else begin
        fetch_ent_t e;
        e = exp_q.pop_front();
        chk("sb_entry", {bus.id_pc, bus.id_inst, bus.id_fault}, 65'(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ent(input logic [31:0] p, input logic [31:0] i, input logic f);
    fetch_ent_t e;
    e.pc = p; e.inst = i; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic flush_to(input logic [31:0] t);
    step();
    flush = 1'b1;
    tgt   = t;
    step();
    flush = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  initial begin
    bus.imem_gnt = 1'b0;
    bus.id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    #3;
    chk("rst_ctrl", 65'({bus.imem_req, pc_en, bus.id_valid, bus.id_fault}), 65'd0);
    chk("rst_data", {1'b0, bus.id_pc, bus.id_inst}, 65'd0);

    // zero-wait stream from PC 0
    for (int i = 0; i < 8; i++) expect_ent(32'(i * 4), 32'(i * 4) + 32'h1000_0000, 1'b0);
    step();
    rst = 1'b0;
    #3;
    chk("stream_c0", 65'({pc_en, bus.id_valid}), 65'b10);
    for (int i = 1; i < 10; i++) begin
      step();
      if (i == 8) bus.imem_gnt = 1'b0;
      #3;
      chk("stream_pc_en", 65'(pc_en), 65'(i < 8));
      if (i == 1) chk("stream_lat", 65'(bus.id_valid), 65'd0);
      else        chk("stream_pc", {bus.id_valid, bus.id_pc}, {32'd0, 1'b1, 32'((i - 2) * 4)});
    end
    step();
    #3;
    chk("stream_done", 65'(bus.id_valid), 65'd0);

    // decode stall with PC at 0x20
    for (int a = 32'h20; a <= 32'h34; a += 4) expect_ent(32'(a), 32'(a) + 32'h1000_0000, 1'b0);
    n_en = 0;
    step();
    bus.id_ready = 1'b0;
    bus.imem_gnt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #3;
      if (pc_en) n_en++;
      if (k >= 2) chk("stall_hold", {bus.id_valid, bus.id_pc, bus.id_inst},
                      {1'b1, 32'h0000_0020, 32'h1000_0020});
      if (k == 4) chk("stall_req", 65'(bus.imem_req), 65'd0);
      step();
    end
    chk("stall_grants", 65'(n_en), 65'd2);
    bus.id_ready = 1'b1;
    repeat (4) step();
    bus.imem_gnt = 1'b0;
    repeat (6) step();

    // flush with two outstanding requests (0x38, 0x3C)
    resp_en = 1'b0;
    bus.imem_gnt = 1'b1;
    step();
    step();
    bus.imem_gnt = 1'b0;
    #3;
    chk("flush_full_req", 65'(bus.imem_req), 65'd0);
    expect_ent(32'h100, 32'h1000_0100, 1'b0);
    flush_to(32'h100);
    resp_en = 1'b1;
    bus.imem_gnt = 1'b1;
    #3;
    chk("flush_target", {32'd0, pc_en, bus.imem_addr}, {32'd0, 1'b1, 32'h100});
    step();
    bus.imem_gnt = 1'b0;
    repeat (8) step();

    // misaligned PC
    expect_ent(32'h102, 32'h0000_0013, 1'b1);
    flush_to(32'h102);
    bus.imem_gnt = 1'b1;
    #3;
    chk("mis_noreq", 65'(bus.imem_req), 65'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      #3;
      chk("mis_block", 65'({bus.imem_req, pc_en}), 65'd0);
    end
    expect_ent(32'h200, 32'h1000_0200, 1'b0);
    flush_to(32'h200);
    #3;
    chk("mis_recover", 65'(pc_en), 65'd1);
    step();
    bus.imem_gnt = 1'b0;
    repeat (5) step();

    // bus error at 0x40; 0x44 is already granted when the error returns
    err_addr = 32'h40;
    expect_ent(32'h40, 32'h1000_0040, 1'b1);
    expect_ent(32'h44, 32'h1000_0044, 1'b0);
    flush_to(32'h40);
    bus.imem_gnt = 1'b1;
    #3;
    chk("err_gnt0", 65'(pc_en), 65'd1);
    step();
    #3;
    chk("err_gnt1", 65'(pc_en), 65'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      #3;
      chk("err_block", 65'(bus.imem_req), 65'd0);
    end
    err_addr = 32'hFFFF_FFFF;
    expect_ent(32'h300, 32'h1000_0300, 1'b0);
    flush_to(32'h300);
    #3;
    chk("err_recover", 65'(pc_en), 65'd1);
    step();
    bus.imem_gnt = 1'b0;
    repeat (5) step();

    // reset with one request outstanding, its response arrives after release
    resp_en = 1'b0;
    bus.imem_gnt = 1'b1;
    step();
    bus.imem_gnt = 1'b0;
    #1;
    rst = 1'b1;
    #2;
    chk("midrst_ctrl", 65'({bus.imem_req, pc_en, bus.id_valid, bus.id_fault}), 65'd0);
    chk("midrst_data", {1'b0, bus.id_pc, bus.id_inst}, 65'd0);
    step();
    step();
    rst = 1'b0;
    resp_en = 1'b1;
    repeat (3) step();
    #3;
    chk("late_rvalid", 65'(bus.id_valid), 65'd0);
    expect_ent(32'h0, 32'h1000_0000, 1'b0);
    bus.imem_gnt = 1'b1;
    #1;
    chk("post_rst_gnt", {32'd0, pc_en, bus.imem_addr}, {32'd0, 1'b1, 32'h0});
    step();
    bus.imem_gnt = 1'b0;
    repeat (6) step();

    chk("sb_empty", 65'(exp_q.size()), 65'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage sitting directly downstream of the `pc` register and upstream of decode. Each cycle it issues the current PC to the instruction memory over a request/grant/response bus, and advances the PC only when the memory grants the request. Returned instruction words are buffered in a 2-entry queue and presented to decode with a valid/ready handshake. On a redirect it discards stale in-flight responses.

## Interface
- `RESET_PC`, default `` `RESET_PC `` (from `cpu.vh`): informational only; the reset value lives in `pc`.
- `NOP_INST`, default 32'h0000_0013: word delivered with a fault entry.
- `clk` in 1: core clock; single clock domain.
- `rst` in 1: reset, asynchronous and active-high.
- `pc_i` in 32: current PC from `pc`.
- `pc_en_o` out 1: PC advance enable to `pc`; high for exactly one cycle per accepted fetch.
- `flush_i` in 1: redirect (jalr, taken branch, jal); `pc_i` holds the new target from the next cycle.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: word address, equal to `pc_i`.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response valid.
- `imem_rdata_i` in 32: instruction word.
- `imem_err_i` in 1: bus error, qualified by `imem_rvalid_i`.
- `id_valid_o` out 1: an entry is available to decode.
- `id_ready_i` in 1: decode accepts the entry.
- `id_pc_o` out 32: PC of the presented instruction.
- `id_inst_o` out 32: presented instruction word.
- `id_fault_o` out 1: entry is a fault (misaligned PC or bus error).

## Operation
- **Tracked state:**
  - `outst`: outstanding granted requests, 0..2.
  - `drop`: responses still to be discarded, 0..2.
  - Buffer: 2 entries of {pc, inst, fault}, with `count` 0..2.
  - PC FIFO: 2 entries, holding the PC of each outstanding request.
- **Issue condition:** `imem_req_o = !flush_i && !fault_pending && pc_i[1:0]==0 && (outst + count) < 2`. A grant pushes `pc_i` into the PC FIFO and pulses `pc_en_o`.
- **Misaligned PC:** when `pc_i[1:0]!=0`, no flush is in progress, `outst==0` and `drop==0`:
  - No bus request is made.
  - A fault entry {pc_i, `NOP_INST`, 1} is enqueued once.
  - `fault_pending` is set, which blocks further issue until `flush_i`.
- **Response handling:**
  - `imem_rvalid_i` with `drop>0`: decrement `drop`; nothing is enqueued.
  - Otherwise, enqueue {PC FIFO head, `imem_rdata_i`, `imem_err_i`}.
  - An error response also sets `fault_pending`.
  - `imem_rvalid_i` with `outst==0` is ignored. This covers responses arriving after reset.
- **Dequeue:** occurs when `id_valid_o && id_ready_i`. Enqueue and dequeue may happen in the same cycle.
- **Flush:**
  - The buffer is emptied, regardless of `id_ready_i`.
  - `drop <= outst - (imem_rvalid_i ? 1 : 0)`, and `outst` is treated as 0 for issue purposes.
  - `fault_pending` is cleared.
  - A response arriving in the flush cycle is dropped.
- **Credit invariant:** `outst + count <= 2`, so no response is ever lost to a full buffer.

## Timing
- **Reset values:**
  - `pc_en_o`, `imem_req_o`, `id_valid_o`, `id_fault_o` are 0.
  - `id_pc_o` and `id_inst_o` are 0.
  - All counters and `fault_pending` are 0.
- `imem_req_o`, `imem_addr_o` and `pc_en_o` are combinational from `pc_i` and registered state.
- Responses arrive no earlier than the cycle after grant.
- **Latency:** grant in cycle N with response in N+1 gives `id_valid_o` in N+2. The buffer output is registered.
- With zero-wait memory and decode always ready, throughput is 1 instruction per cycle.
- `id_*` outputs are held stable while `id_valid_o && !id_ready_i`.
- Assertion of `rst` mid-operation clears all state immediately.

## Structure
- `cpu.vh` holds `RESET_PC`, `NOP_INST` and the fault-entry field widths.
- Sub-module `if_buf` is a 2-entry synchronous FIFO with a flush input, instantiated twice: once for the PC FIFO and once for the output buffer.

## Test plan
- **Zero-wait stream:** PC 0,4,8,… with gnt=1, rvalid one cycle later, ready=1 → `id_valid_o` from cycle 2; `id_pc_o`=0,4,8 on consecutive cycles; `pc_en_o` high every cycle.
- **Decode stall:** ready=0 for 5 cycles → at most 2 grants, then `imem_req_o`=0; `id_*` stable; ready=1 resumes in order with no loss.
- **Flush with 2 outstanding:** flush with outst=2 and target 0x100 → both stale responses dropped; first delivered `id_pc_o`=0x100.
- **Misaligned PC:** `pc_i`=0x102 → no request; one entry with `id_fault_o`=1, `id_inst_o`=0x13; no further issue until flush.
- **Bus error:** rvalid with err=1 at PC 0x40 → entry with fault=1; issue blocked until flush.
- **Reset mid-transfer:** assert `rst` with outst=1; late rvalid after release → ignored; outputs 0 during reset.
